// File: rtl/load_store_unit.sv
// load_store_unit: decodes LOAD/STORE into byte-lane memory requests, drives store data, captures extended load data.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses are flagged and suppressed instead of aligned down.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misaligned,
    output logic        memory_interface_enable,
    output logic        memory_interface_state,
    output logic [31:0] memory_interface_address,
    output logic [3:0]  memory_interface_frame_mask,
    inout  wire  [31:0] memory_interface_data,
    input  logic        memory_interface_ready
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_legal;
    logic        w_misalign;
    logic        w_enable;
    logic [1:0]  w_size;
    logic        w_unsigned;
    logic [3:0]  w_mask;
    logic [31:0] w_lane_en;
    logic [31:0] w_store_rep;
    logic [31:0] w_store_bus;
    logic [31:0] w_rd;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;
    logic        w_capture;

    assign w_is_load  = opcode == OP_LOAD;
    assign w_is_store = opcode == OP_STORE;
    assign w_size     = funct3[1:0];
    assign w_unsigned = funct3[2];
    assign w_legal    = (w_is_load && funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                     || (w_is_store && funct3 inside {3'b000, 3'b001, 3'b010});

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = w_legal && ((w_size == SZ_HALF && address[0])
                                 || (w_size == 2'b10 && address[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_enable = w_legal && !w_misalign;
    assign w_mask   = !w_enable             ? 4'b0000
                    : w_size == SZ_BYTE     ? 4'b1000 >> address[1:0]
                    : w_size == SZ_HALF     ? (address[1] ? 4'b0011 : 4'b1100)
                    :                         4'b1111;

    // Mask bit (3-k) enables byte lane k, i.e. bus bits [8k+7:8k].
    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign w_lane_en[8*k +: 8] = {8{w_mask[3-k]}};
    end

    assign w_store_rep = w_size == SZ_BYTE ? {4{store_data[7:0]}}
                       : w_size == SZ_HALF ? {2{store_data[15:0]}}
                       :                     store_data;
    assign w_store_bus = w_store_rep & w_lane_en;

    assign memory_interface_enable     = w_enable;
    assign memory_interface_state      = w_is_store;
    assign memory_interface_address    = {address[31:2], 2'b00};
    assign memory_interface_frame_mask = w_mask;
    assign memory_interface_data       = (w_enable && w_is_store) ? w_store_bus : 32'bz;
    assign misaligned                  = w_misalign;

    assign w_rd   = memory_interface_data;
    assign w_byte = address[1:0] == 2'd0 ? w_rd[7:0]
                  : address[1:0] == 2'd1 ? w_rd[15:8]
                  : address[1:0] == 2'd2 ? w_rd[23:16]
                  :                        w_rd[31:24];
    assign w_half = address[1] ? w_rd[31:16] : w_rd[15:0];
    assign w_ext  = w_size == SZ_BYTE ? {{24{~w_unsigned & w_byte[7]}}, w_byte}
                  : w_size == SZ_HALF ? {{16{~w_unsigned & w_half[15]}}, w_half}
                  :                     w_rd;

    assign w_capture = w_enable && !w_is_store && memory_interface_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_data  <= 32'd0;
            load_valid <= 1'b0;
        end else begin
            load_valid <= w_capture;
            if (w_capture)
                load_data <= w_ext;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a lane-arithmetic reference model.
// Honors MISALIGN_TRAP_EN the same way as the design build.
module tb_load_store_unit;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misaligned;
    logic        mem_en;
    logic        mem_state;
    logic [31:0] mem_addr;
    logic [3:0]  mem_mask;
    wire  [31:0] mem_data;
    logic        mem_ready;
    logic        tb_drive;
    logic [31:0] tb_bus;
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] m_data;
    logic        m_valid;

    always #5 clk = ~clk;
    assign mem_data = tb_drive ? tb_bus : 32'bz;

    load_store_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .address(address),
        .store_data(store_data), .load_data(load_data), .load_valid(load_valid),
        .misaligned(misaligned), .memory_interface_enable(mem_en),
        .memory_interface_state(mem_state), .memory_interface_address(mem_addr),
        .memory_interface_frame_mask(mem_mask), .memory_interface_data(mem_data),
        .memory_interface_ready(mem_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic txn(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] bd, input logic rdy);
        logic        legal, mis, e, wr;
        int          sz;
        logic [3:0]  mk;
        logic [31:0] sb, ld;
        logic [7:0]  b8;
        logic [15:0] h16;
        @(negedge clk);
        opcode = op; funct3 = f3; address = a; store_data = sd; mem_ready = rdy;
        legal = (op == LOAD && f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
             || (op == STORE && f3 inside {3'd0, 3'd1, 3'd2});
        sz  = int'(f3[1:0]);
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = legal && ((sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00));
`endif
        e  = legal && !mis;
        wr = op == STORE;
        mk = !e ? 4'b0000 : sz == 0 ? 4'(1 << (3 - int'(a[1:0]))) : sz == 1 ? (a[1] ? 4'b0011 : 4'b1100) : 4'b1111;
        sb = sz == 0 ? (32'(sd[7:0]) << (8 * int'(a[1:0]))) : sz == 1 ? (32'(sd[15:0]) << (16 * int'(a[1]))) : sd;
        tb_drive = !(e && wr);
        tb_bus   = bd;
        b8  = 8'(bd >> (8 * int'(a[1:0])));
        h16 = 16'(bd >> (16 * int'(a[1])));
        ld  = sz == 0 ? (f3[2] ? 32'(b8) : 32'($signed(b8)))
            : sz == 1 ? (f3[2] ? 32'(h16) : 32'($signed(h16))) : bd;
        #1;
        check("enable", 32'(mem_en), 32'(e));
        check("state", 32'(mem_state), 32'(wr));
        check("addr", mem_addr, {a[31:2], 2'b00});
        check("mask", 32'(mem_mask), 32'(mk));
        check("misaligned", 32'(misaligned), 32'(mis));
        check("bus", mem_data, (e && wr) ? sb : bd);
        @(posedge clk);
        if (reset && e && !wr && rdy) begin
            m_data  = ld;
            m_valid = 1'b1;
        end else m_valid = 1'b0;
        if (!reset) m_data = 32'd0;
        #1;
        check("load_valid", 32'(load_valid), 32'(m_valid));
        check("load_data", load_data, m_data);
    endtask

    initial begin
        reset = 1'b0; opcode = 7'h13; funct3 = 3'd0; address = 32'd0; store_data = 32'd0;
        mem_ready = 1'b0; tb_drive = 1'b1; tb_bus = 32'd0; m_data = 32'd0; m_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_load_data", load_data, 32'd0);
        check("rst_load_valid", 32'(load_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        txn(STORE, 3'b010, 32'd16, 32'hDEADCAFE, 32'h0, 1'b0);
        check("sw_bus", mem_data, 32'hDEADCAFE);
        txn(LOAD, 3'b010, 32'd20, 32'h0, 32'hDEADBEEF, 1'b1);
        check("lw_data", load_data, 32'hDEADBEEF);
        txn(7'h13, 3'b000, 32'd0, 32'h0, 32'h0, 1'b1);
        check("lw_pulse_end", 32'(load_valid), 32'd0);
        txn(LOAD, 3'b000, 32'd21, 32'h0, 32'hDEADBEEF, 1'b1);
        check("lb_data", load_data, 32'hFFFFFFBE);
        txn(LOAD, 3'b100, 32'd21, 32'h0, 32'hDEADBEEF, 1'b1);
        check("lbu_data", load_data, 32'h000000BE);
        txn(LOAD, 3'b001, 32'd22, 32'h0, 32'hDEADBEEF, 1'b1);
        check("lh_data", load_data, 32'hFFFFDEAD);
        txn(LOAD, 3'b101, 32'd22, 32'h0, 32'hDEADBEEF, 1'b1);
        check("lhu_data", load_data, 32'h0000DEAD);
        txn(STORE, 3'b001, 32'd22, 32'h00001234, 32'h0, 1'b0);
        check("sh_bus", mem_data, 32'h12340000);
        txn(LOAD, 3'b010, 32'd21, 32'h0, 32'h5555AAAA, 1'b1);
        txn(STORE, 3'b100, 32'd8, 32'h12345678, 32'h0F0F0F0F, 1'b1);
        txn(LOAD, 3'b011, 32'd8, 32'h0, 32'h0F0F0F0F, 1'b1);

        // Reset in the middle of a pending load, then ready arriving while reset is held.
        txn(LOAD, 3'b010, 32'd40, 32'h0, 32'hCAFEF00D, 1'b1);
        @(negedge clk);
        mem_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("midrst_data", load_data, 32'd0);
        check("midrst_valid", 32'(load_valid), 32'd0);
        m_data = 32'd0; m_valid = 1'b0;
        txn(LOAD, 3'b010, 32'd40, 32'h0, 32'h11112222, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        txn(LOAD, 3'b010, 32'd40, 32'h0, 32'h33334444, 1'b1);
        check("after_rst_data", load_data, 32'h33334444);

        for (int i = 0; i < 300; i++) begin
            logic [6:0] op;
            int         pick;
            pick = int'($urandom_range(0, 3));
            op = pick == 1 ? STORE : pick == 2 ? 7'($urandom) : LOAD;
            txn(op, 3'($urandom), $urandom, $urandom, $urandom, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
